// File: rtl/mux_arbiter_if.sv
// Handshake bundle between two requesters, the mux arbiter and the shared sink.
// master = requester/sink side, slave = arbiter side.
interface mux_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_lock;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_lock;
    logic             req1_ready;

    logic             selector;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output req0_valid, req0_data, req0_lock,
        input  req0_ready,
        output req1_valid, req1_data, req1_lock,
        input  req1_ready,
        input  selector, out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_lock,
        output req0_ready,
        input  req1_valid, req1_data, req1_lock,
        output req1_ready,
        output selector, out_valid, out_data,
        input  out_ready
    );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin arbiter driving a shared 2:1 datapath mux, with locked bursts and a
// single registered output stage.
module mux_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    mux_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e           state_q;
    logic             last_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;

    logic can_load;
    logic sel;
    logic ready0;
    logic ready1;
    logic xfer0;
    logic xfer1;

    always_comb begin
        can_load = !out_valid_q || bus.out_ready;

        // Idle with no or both requests falls back to round-robin on the last grant.
        sel = ~last_q;
        case (state_q)
            StOwn0:  sel = 1'b0;
            StOwn1:  sel = 1'b1;
            default: begin
                if (bus.req0_valid && !bus.req1_valid) begin
                    sel = 1'b0;
                end else if (bus.req1_valid && !bus.req0_valid) begin
                    sel = 1'b1;
                end
            end
        endcase

        ready0 = can_load && !sel && rst_n;
        ready1 = can_load && sel && rst_n;
        xfer0  = bus.req0_valid && ready0;
        xfer1  = bus.req1_valid && ready1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (xfer0) begin
            out_data_q  <= bus.req0_data;
            out_valid_q <= 1'b1;
            last_q      <= 1'b0;
            state_q     <= bus.req0_lock ? StOwn0 : StIdle;
        end else if (xfer1) begin
            out_data_q  <= bus.req1_data;
            out_valid_q <= 1'b1;
            last_q      <= 1'b1;
            state_q     <= bus.req1_lock ? StOwn1 : StIdle;
        end else if (bus.out_ready) begin
            // Drain only; out_data keeps the last word.
            out_valid_q <= 1'b0;
        end
    end

    assign bus.selector   = sel;
    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: a per-cycle reference model plus literal checkpoints.
module tb_mux_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mux_arbiter_if #(.WIDTH(32)) bus ();

    mux_arbiter #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner of a lock (-1 none), last grant, output stage contents.
    int          m_owner = -1;
    bit          m_last  = 1'b1;
    bit          m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    bit          mv[2];
    bit          ml[2];
    logic [31:0] md[2];
    bit          er[2];
    bit          es;
    bit          cl;
    int          g;

    always @(negedge clk) begin
        #4;
        mv[0] = bus.req0_valid;
        mv[1] = bus.req1_valid;
        ml[0] = bus.req0_lock;
        ml[1] = bus.req1_lock;
        md[0] = bus.req0_data;
        md[1] = bus.req1_data;
        if (m_owner >= 0)        es = (m_owner == 1);
        else if (mv[0] && !mv[1]) es = 1'b0;
        else if (mv[1] && !mv[0]) es = 1'b1;
        else                      es = !m_last;
        cl    = !m_valid || bus.out_ready;
        er[0] = rst_n && cl && (es == 1'b0);
        er[1] = rst_n && cl && (es == 1'b1);

        chk("m_selector", 32'(bus.selector), 32'(es));
        chk("m_req0_ready", 32'(bus.req0_ready), 32'(er[0]));
        chk("m_req1_ready", 32'(bus.req1_ready), 32'(er[1]));
        chk("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("m_out_data", bus.out_data, m_data);

        if (!rst_n) begin
            m_owner = -1;
            m_last  = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            g = -1;
            for (int n = 0; n < 2; n++) if (mv[n] && er[n]) g = n;
            if (g >= 0) begin
                m_data  = md[g];
                m_valid = 1'b1;
                m_last  = (g == 1);
                m_owner = ml[g] ? g : -1;
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic drive(input bit v0, input logic [31:0] d0, input bit l0,
                         input bit v1, input logic [31:0] d1, input bit l1, input bit ordy);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req0_lock  = l0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.req1_lock  = l1;
        bus.out_ready  = ordy;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive(1, 32'h0, 0, 0, 32'h0, 0, 1);

        // Reset held two cycles, then a single requester.
        @(negedge clk); #4;
        chk("t1_rst_ready0", 32'(bus.req0_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req0_data = 32'h1;
        #4;
        chk("t1_ready0", 32'(bus.req0_ready), 32'd1);
        chk("t1_selector", 32'(bus.selector), 32'd0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #4;
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_out_data", bus.out_data, 32'h1);

        // Round-robin: last grant was 0, so requester 1 goes first.
        @(negedge clk);
        drive(1, 32'hAAAA0000, 0, 1, 32'h5555FFFF, 0, 1);
        #4;
        chk("t2_sel_a", 32'(bus.selector), 32'd1);
        @(negedge clk); #4;
        chk("t2_sel_b", 32'(bus.selector), 32'd0);
        chk("t2_data_b", bus.out_data, 32'h5555FFFF);
        @(negedge clk); #4;
        chk("t2_sel_c", 32'(bus.selector), 32'd1);
        chk("t2_data_c", bus.out_data, 32'hAAAA0000);
        @(negedge clk); #4;
        chk("t2_sel_d", 32'(bus.selector), 32'd0);
        chk("t2_data_d", bus.out_data, 32'h5555FFFF);

        // Locked burst by requester 1 while requester 0 keeps asking.
        @(negedge clk);
        drive(1, 32'hAAAA0000, 0, 1, 32'h1, 1, 1);
        #4;
        chk("t3_ready0_b1", 32'(bus.req0_ready), 32'd0);
        chk("t3_sel_b1", 32'(bus.selector), 32'd1);
        for (int b = 2; b <= 4; b++) begin
            @(negedge clk);
            bus.req1_data = 32'(b);
            bus.req1_lock = (b < 4);
            #4;
            chk("t3_ready0_burst", 32'(bus.req0_ready), 32'd0);
            chk("t3_data_burst", bus.out_data, 32'(b - 1));
        end
        @(negedge clk);
        drive(1, 32'hAAAA0000, 1, 1, 32'h5, 0, 1);
        #4;
        chk("t3_ready0_after", 32'(bus.req0_ready), 32'd1);
        chk("t3_data_4", bus.out_data, 32'h4);

        // Requester 0 now owns the lock; bubble for two cycles.
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #4;
        chk("t4_sel_a", 32'(bus.selector), 32'd0);
        chk("t4_ready1_a", 32'(bus.req1_ready), 32'd0);
        chk("t4_valid_a", 32'(bus.out_valid), 32'd1);
        @(negedge clk); #4;
        chk("t4_sel_b", 32'(bus.selector), 32'd0);
        chk("t4_ready1_b", 32'(bus.req1_ready), 32'd0);
        chk("t4_valid_b", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        drive(1, 32'h12345678, 0, 1, 32'h5, 0, 1);
        #4;
        chk("t4_ready0_resume", 32'(bus.req0_ready), 32'd1);

        // Back-pressure: load 0xDEADBEEF from requester 1, then stall.
        @(negedge clk);
        drive(0, 32'h0, 0, 1, 32'hDEADBEEF, 0, 1);
        #4;
        chk("t4_data", bus.out_data, 32'h12345678);
        @(negedge clk);
        drive(1, 32'h11111111, 0, 1, 32'h22222222, 0, 0);
        for (int s = 0; s < 2; s++) begin
            #4;
            chk("t5_stall_ready0", 32'(bus.req0_ready), 32'd0);
            chk("t5_stall_ready1", 32'(bus.req1_ready), 32'd0);
            chk("t5_stall_data", bus.out_data, 32'hDEADBEEF);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #4;
        chk("t5_load_ready0", 32'(bus.req0_ready), 32'd1);

        // Enter OWN1 with a valid word, then reset in the middle of it.
        @(negedge clk);
        drive(1, 32'h11111111, 0, 1, 32'h33333333, 1, 1);
        #4;
        chk("t5_load_valid", 32'(bus.out_valid), 32'd1);
        chk("t5_load_data", bus.out_data, 32'h11111111);
        @(negedge clk);
        rst_n = 1'b0;
        #4;
        chk("t6_rst_ready1", 32'(bus.req1_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h44444444, 0, 1, 32'h55555555, 0, 1);
        #4;
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_out_data", bus.out_data, 32'h0);
        chk("t6_sel", 32'(bus.selector), 32'd0);
        chk("t6_ready0", 32'(bus.req0_ready), 32'd1);

        // Mixed sweep; the model checks every cycle.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) != 0));
        end

        @(negedge clk); #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
